ysyx_22040632_mul_iter: RTL and testbench

YSYX_22040632_MUL_ITER -- requirements
Module: ysyx_22040632_mul_iter

---
 rtl/ysyx_22040632_mul_iter.sv | 91 +++++++++
 tb/tb_ysyx_22040632_mul_iter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/ysyx_22040632_mul_iter.sv
// ysyx_22040632_mul_iter: iterative radix-4 booth multiplier, 64x64->128 or 32-bit mulw,
// one booth digit per cycle with valid/ready handshakes on both sides.
module ysyx_22040632_mul_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        x_signed,
    input  logic        y_signed,
    input  logic        mulw,
    input  logic [63:0] multiplicand,
    input  logic [63:0] multiplier,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] result_hi,
    output logic [63:0] result_lo
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state_q, state_d;
    logic [127:0] x_q, x_d, acc_q, acc_d, x_ext, pp;
    logic [66:0] scan_q, scan_d, y_scan;
    logic [5:0] idx_q, idx_d;
    logic mulw_q, mulw_d, xs, ys;
    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign result_hi = acc_q[127:64];
    assign result_lo = mulw_q ? {{32{acc_q[31]}}, acc_q[31:0]} : acc_q[63:0];
    always_comb begin
        xs = x_signed & (mulw ? multiplicand[31] : multiplicand[63]);
        ys = y_signed & (mulw ? multiplier[31] : multiplier[63]);
        x_ext = mulw ? {{96{xs}}, multiplicand[31:0]} : {{64{xs}}, multiplicand};
        // scan register carries the implicit zero below y bit 0
        y_scan = mulw ? {{34{ys}}, multiplier[31:0], 1'b0} : {{2{ys}}, multiplier, 1'b0};
        case (scan_q[2:0])
            3'b001, 3'b010: pp = x_q;
            3'b011:         pp = x_q << 1;
            3'b100:         pp = -(x_q << 1);
            3'b101, 3'b110: pp = -x_q;
            default:        pp = '0;
        endcase
        state_d = state_q;
        x_d     = x_q;
        acc_d   = acc_q;
        scan_d  = scan_q;
        idx_d   = idx_q;
        mulw_d  = mulw_q;
        if (flush) begin
            state_d = IDLE;
            acc_d   = '0;
            scan_d  = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    state_d = BUSY;
                    x_d     = x_ext;
                    scan_d  = y_scan;
                    acc_d   = '0;
                    idx_d   = '0;
                    mulw_d  = mulw;
                end
                BUSY: begin
                    acc_d  = acc_q + (pp << {idx_q, 1'b0});
                    scan_d = scan_q >> 2;
                    idx_d  = idx_q + 6'd1;
                    if (idx_q == (mulw_q ? 6'd16 : 6'd32)) state_d = DONE;
                end
                DONE: if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            acc_q   <= '0;
            scan_q  <= '0;
            idx_q   <= '0;
            mulw_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            acc_q   <= acc_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            mulw_q  <= mulw_d;
        end
    end
endmodule

// File: tb/tb_ysyx_22040632_mul_iter.sv
// tb_ysyx_22040632_mul_iter: directed checks of products, latency, backpressure, flush and reset.
module tb_ysyx_22040632_mul_iter;
    logic clk = 1'b0;
    logic rst, in_valid, x_signed, y_signed, mulw, flush, out_ready;
    logic [63:0] multiplicand, multiplier;
    logic in_ready, out_valid;
    logic [63:0] result_hi, result_lo;
    int tests = 0;
    int fails = 0;

    ysyx_22040632_mul_iter dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x_signed(x_signed), .y_signed(y_signed), .mulw(mulw),
        .multiplicand(multiplicand), .multiplier(multiplier), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .result_hi(result_hi), .result_lo(result_lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag, input logic xs, input logic ys, input logic w,
                       input logic [63:0] x, input logic [63:0] y, input int lat,
                       input logic [63:0] ehi, input logic [63:0] elo, input int hold);
        int cnt;
        logic stable;
        @(negedge clk);
        x_signed = xs; y_signed = ys; mulw = w;
        multiplicand = x; multiplier = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        multiplicand = {$urandom, $urandom};
        multiplier = {$urandom, $urandom};
        x_signed = ~xs; y_signed = ~ys; mulw = ~w;
        chk({tag, "_busy_ready"}, 64'(in_ready), 64'd0);
        cnt = 0;
        while (!out_valid && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk({tag, "_latency"}, 64'(cnt), 64'(lat));
        chk({tag, "_hi"}, result_hi, ehi);
        chk({tag, "_lo"}, result_lo, elo);
        if (hold > 0) begin
            stable = 1'b1;
            in_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                if (result_hi !== ehi || result_lo !== elo || !out_valid || in_ready) stable = 1'b0;
            end
            in_valid = 1'b0;
            chk({tag, "_hold_stable"}, 64'(stable), 64'd1);
            chk({tag, "_hold_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_ret_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_ret_valid"}, 64'(out_valid), 64'd0);
    endtask

    task automatic abort(input string tag, input logic use_rst, input int idx);
        logic seen;
        @(negedge clk);
        x_signed = 1'b0; y_signed = 1'b0; mulw = 1'b0;
        multiplicand = 64'h1234_5678_9ABC_DEF0; multiplier = 64'h0FED_CBA9_8765_4321;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (idx) @(posedge clk);
        #1;
        if (use_rst) rst = 1'b1; else flush = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk({tag, "_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_lo_clear"}, result_lo, 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid || !in_ready) seen = 1'b1;
        end
        chk({tag, "_no_valid"}, 64'(seen), 64'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; x_signed = 1'b0; y_signed = 1'b0; mulw = 1'b0;
        flush = 1'b0; out_ready = 1'b0; multiplicand = '0; multiplier = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_ready", 64'(in_ready), 64'd1);
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_hi", result_hi, 64'd0);
        chk("reset_lo", result_lo, 64'd0);
        run("u64", 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 33,
            64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0001, 10);
        run("s64", 1, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 33,
            64'h0, 64'h8000_0000_0000_0000, 0);
        run("mix_xs", 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 33,
            64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFA, 0);
        run("mix_ys", 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 33,
            64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 0);
        run("minneg", 1, 1, 0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 33,
            64'h4000_0000_0000_0000, 64'h0, 0);
        run("w_s", 1, 1, 1, 64'hDEAD_BEEF_7FFF_FFFF, 64'h0123_4567_0000_0002, 17,
            64'h0, 64'hFFFF_FFFF_FFFF_FFFE, 0);
        run("w_u", 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 17,
            64'h0, 64'h0000_0000_0000_0001, 0);
        run("w_neg", 1, 1, 1, 64'h0000_0000_FFFF_FFFD, 64'hFFFF_FFFF_0000_0005, 17,
            64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF1, 0);
        abort("flush", 1'b0, 5);
        abort("rst", 1'b1, 20);
        run("after_rst", 0, 0, 0, 64'd3, 64'd5, 33, 64'h0, 64'd15, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
